// File: rtl/flap_game_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// flap_pkg
// Shared types and constants for the flap game sequencer.
//   flap_state_t : round life-cycle state, encoded as shown on the overlay
//   KEY_*        : USB keycodes that start a round
//   BCD_W        : width of the 3-digit BCD score
//   bcd_inc3()   : 3-digit BCD increment with digit carry (wraps at 999)
// -----------------------------------------------------------------------------
package flap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_CRASH = 3'd3,
        ST_OVER  = 3'd4
    } flap_state_t;

    localparam logic [7:0] KEY_SPACE  = 8'h2C;
    localparam logic [7:0] KEY_W      = 8'h1A;
    localparam logic [7:0] KEY_MECH_W = 8'hCC;

    localparam int              BCD_W   = 12;
    localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;

    // Increment a 3-digit BCD value; callers guard against 999.
    function automatic logic [BCD_W-1:0] bcd_inc3(input logic [BCD_W-1:0] v);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        {d2, d1, d0} = v;
        if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
        end else begin
            d0 = 4'd0;
            if (d1 != 4'd9) begin
                d1 = d1 + 4'd1;
            end else begin
                d1 = 4'd0;
                d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
            end
        end
        return {d2, d1, d0};
    endfunction

endpackage

// File: rtl/flap_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// flap_game_if
// Signal bundle between the game sequencer and its surroundings.
//   key        : current USB keycode (8'h00 = none)
//   gameover   : bird hit top/bottom boundary
//   collide    : bird overlaps an obstacle
//   pass_obs   : one-frame pulse, obstacle passed the bird
//   rdy        : motion enable to bird/obstacles
//   obj_reset  : one-frame re-centre pulse
//   state_code : current state for the overlay
//   countdown  : frames left in READY/CRASH, saturated at 127
//   score      : BCD score of the current round
//   hiscore    : BCD best score (0 when the feature is not built)
// Modports: slave = sequencer side, master = keyboard/motion/overlay side.
// -----------------------------------------------------------------------------
interface flap_game_if;
    import flap_pkg::*;

    logic [7:0]       key;
    logic             gameover;
    logic             collide;
    logic             pass_obs;
    logic             rdy;
    logic             obj_reset;
    logic [2:0]       state_code;
    logic [6:0]       countdown;
    logic [BCD_W-1:0] score;
    logic [BCD_W-1:0] hiscore;

    modport slave (
        input  key, gameover, collide, pass_obs,
        output rdy, obj_reset, state_code, countdown, score, hiscore
    );

    modport master (
        output key, gameover, collide, pass_obs,
        input  rdy, obj_reset, state_code, countdown, score, hiscore
    );

endinterface

// File: rtl/flap_game_ctrl_bcd_counter3.sv
// -----------------------------------------------------------------------------
// bcd_counter3
// 3-digit BCD counter that saturates at 999.
//   frame_clk : clock
//   Reset     : synchronous active-high clear
//   clr       : synchronous clear (round start)
//   inc       : count up by one when not saturated
//   count     : BCD value
// -----------------------------------------------------------------------------
module bcd_counter3
    import flap_pkg::*;
(
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge frame_clk) begin
        if (Reset || clr) begin
            count <= '0;
        end else if (inc && (count != BCD_MAX)) begin
            count <= bcd_inc3(count);
        end
    end

endmodule

// File: rtl/flap_game_ctrl.sv
// -----------------------------------------------------------------------------
// flap_game_ctrl
// Round sequencer for the flap game: IDLE -> READY -> PLAY -> CRASH -> OVER.
// Runs once per video frame; owns rdy, obj_reset, score and high score.
//   frame_clk : frame clock
//   Reset     : synchronous active-high reset
//   bus       : flap_game_if.slave (key/crash/pass in, overlay/motion out)
// Optional feature: define FLAP_HISCORE_EN to build the high-score register;
// otherwise hiscore is tied to zero.
// -----------------------------------------------------------------------------
module flap_game_ctrl
    import flap_pkg::*;
#(
    parameter int         READY_FRAMES = 60,
    parameter int         CRASH_FRAMES = 90,
    parameter logic [7:0] START_KEY    = KEY_SPACE,
    parameter logic [7:0] FLAP_KEY0    = KEY_W,
    parameter logic [7:0] FLAP_KEY1    = KEY_MECH_W
) (
    input  logic       frame_clk,
    input  logic       Reset,
    flap_game_if.slave bus
);

    localparam int MAX_FR = (READY_FRAMES > CRASH_FRAMES) ? READY_FRAMES : CRASH_FRAMES;
    localparam int CNT_W  = (MAX_FR > 1) ? $clog2(MAX_FR) : 1;
    localparam logic [CNT_W-1:0] READY_LOAD = CNT_W'(READY_FRAMES - 1);
    localparam logic [CNT_W-1:0] CRASH_LOAD = CNT_W'(CRASH_FRAMES - 1);

    flap_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       prev_key;
    logic             rdy_q;
    logic             obj_reset_q;
    logic [6:0]       countdown_q;
    logic [BCD_W-1:0] score_q;

    logic start_ev;
    logic crash;
    logic score_clr;
    logic score_inc;

    function automatic logic is_start_key(input logic [7:0] k);
        return (k == START_KEY) || (k == FLAP_KEY0) || (k == FLAP_KEY1);
    endfunction

    function automatic logic [6:0] clip_cd(input logic [CNT_W-1:0] v);
        logic [31:0] w;
        w = 32'(v);
        return (w > 32'd127) ? 7'd127 : w[6:0];
    endfunction

    // Edge-detect against the previous frame's key so a held key fires once.
    assign start_ev = is_start_key(bus.key) && !is_start_key(prev_key);
    assign crash    = bus.gameover | bus.collide;

    // Score clears on the same edge that enters READY; crash beats a pass.
    assign score_clr = start_ev && ((state == ST_IDLE) || (state == ST_OVER));
    assign score_inc = (state == ST_PLAY) && bus.pass_obs && !crash;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            prev_key    <= 8'h00;
            rdy_q       <= 1'b0;
            obj_reset_q <= 1'b0;
            countdown_q <= 7'd0;
        end else begin
            prev_key    <= bus.key;
            obj_reset_q <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_ev) begin
                        state       <= ST_READY;
                        cnt         <= READY_LOAD;
                        countdown_q <= clip_cd(READY_LOAD);
                        obj_reset_q <= 1'b1;
                        rdy_q       <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (cnt == '0) begin
                        state       <= ST_PLAY;
                        rdy_q       <= 1'b1;
                        countdown_q <= 7'd0;
                    end else begin
                        cnt         <= cnt - CNT_W'(1);
                        countdown_q <= clip_cd(cnt - CNT_W'(1));
                    end
                end
                ST_PLAY: begin
                    if (crash) begin
                        state       <= ST_CRASH;
                        rdy_q       <= 1'b0;
                        cnt         <= CRASH_LOAD;
                        countdown_q <= clip_cd(CRASH_LOAD);
                    end
                end
                ST_CRASH: begin
                    if (cnt == '0) begin
                        state       <= ST_OVER;
                        countdown_q <= 7'd0;
                    end else begin
                        cnt         <= cnt - CNT_W'(1);
                        countdown_q <= clip_cd(cnt - CNT_W'(1));
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    rdy_q       <= 1'b0;
                    countdown_q <= 7'd0;
                end
            endcase
        end
    end

    bcd_counter3 u_score (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clr       (score_clr),
        .inc       (score_inc),
        .count     (score_q)
    );

`ifdef FLAP_HISCORE_EN
    logic [BCD_W-1:0] hiscore_q;

    // Updated on the CRASH->OVER edge; score is frozen throughout CRASH.
    // BCD digits are ordered like binary, so a plain unsigned compare works.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            hiscore_q <= '0;
        end else if ((state == ST_CRASH) && (cnt == '0) && (score_q > hiscore_q)) begin
            hiscore_q <= score_q;
        end
    end

    assign bus.hiscore = hiscore_q;
`else
    assign bus.hiscore = '0;
`endif

    assign bus.state_code = state;
    assign bus.rdy        = rdy_q;
    assign bus.obj_reset  = obj_reset_q;
    assign bus.countdown  = countdown_q;
    assign bus.score      = score_q;

endmodule

// File: tb/tb_flap_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flap_game_ctrl
// Self-checking bench for flap_game_ctrl. A frame-level reference model
// (decimal score, elapsed-frame counters) is stepped alongside the DUT and
// every output is compared after each frame edge. Directed rounds cover start,
// held key, scoring, saturation, crash/pass collision and mid-round reset,
// followed by randomized key/crash/pass traffic.
// -----------------------------------------------------------------------------
module tb_flap_game_ctrl;

    localparam int RF = 130;   // long enough to exercise countdown saturation
    localparam int CF = 3;

    localparam int S_IDLE  = 0;
    localparam int S_READY = 1;
    localparam int S_PLAY  = 2;
    localparam int S_CRASH = 3;
    localparam int S_OVER  = 4;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    always #5 frame_clk = ~frame_clk;

    flap_game_if gif();

    flap_game_ctrl #(
        .READY_FRAMES (RF),
        .CRASH_FRAMES (CF)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (gif)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_state   = S_IDLE;
    int         m_elapsed = 0;
    int         m_score   = 0;
    int         m_hi      = 0;
    bit         m_obj     = 1'b0;
    logic [7:0] m_prev    = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_start(input logic [7:0] k);
        return (k == 8'h2C) || (k == 8'h1A) || (k == 8'hCC);
    endfunction

    function automatic logic [11:0] to_bcd(input int s);
        return 12'((s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10));
    endfunction

    function automatic int min127(input int v);
        return (v > 127) ? 127 : v;
    endfunction

    task automatic model_update(input bit rst, input logic [7:0] k,
                                input bit go, input bit col, input bit pass);
        bit start;
        start = is_start(k) && !is_start(m_prev);
        m_obj = 1'b0;
        if (rst) begin
            m_state = S_IDLE; m_elapsed = 0; m_score = 0; m_hi = 0; m_prev = 8'h00;
            return;
        end
        m_prev = k;
        case (m_state)
            S_IDLE, S_OVER: if (start) begin
                m_state = S_READY; m_elapsed = 0; m_score = 0; m_obj = 1'b1;
            end
            S_READY: if (m_elapsed == RF - 1) m_state = S_PLAY; else m_elapsed++;
            S_PLAY: begin
                if (go || col) begin
                    m_state = S_CRASH; m_elapsed = 0;
                end else if (pass && m_score < 999) begin
                    m_score++;
                end
            end
            S_CRASH: begin
                if (m_elapsed == CF - 1) begin
                    m_state = S_OVER;
                    if (m_score > m_hi) m_hi = m_score;
                end else begin
                    m_elapsed++;
                end
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    task automatic compare_all();
        int cd;
        cd = 0;
        if (m_state == S_READY) cd = min127(RF - 1 - m_elapsed);
        if (m_state == S_CRASH) cd = min127(CF - 1 - m_elapsed);
        check("state_code", 32'(gif.state_code), 32'(m_state));
        check("rdy",        32'(gif.rdy),        32'(m_state == S_PLAY));
        check("obj_reset",  32'(gif.obj_reset),  32'(m_obj));
        check("countdown",  32'(gif.countdown),  32'(cd));
        check("score",      32'(gif.score),      32'(to_bcd(m_score)));
`ifdef FLAP_HISCORE_EN
        check("hiscore",    32'(gif.hiscore),    32'(to_bcd(m_hi)));
`else
        check("hiscore",    32'(gif.hiscore),    32'h0);
`endif
    endtask

    // One frame: drive inputs, take the edge, advance the model, compare.
    task automatic step(input bit rst, input logic [7:0] k,
                        input bit go, input bit col, input bit pass);
        Reset        = rst;
        gif.key      = k;
        gif.gameover = go;
        gif.collide  = col;
        gif.pass_obs = pass;
        @(posedge frame_clk);
        model_update(rst, k, go, col, pass);
        #1;
        compare_all();
    endtask

    initial begin
        gif.key      = 8'h00;
        gif.gameover = 1'b0;
        gif.collide  = 1'b0;
        gif.pass_obs = 1'b0;

        // Power-up and start
        step(1, 8'h00, 0, 0, 0);
        step(1, 8'h00, 0, 0, 0);
        check("reset_state", 32'(gif.state_code), 32'(S_IDLE));
        step(0, 8'h2C, 0, 0, 0);
        check("start_obj_reset", 32'(gif.obj_reset), 32'd1);
        check("start_countdown_sat", 32'(gif.countdown), 32'd127);
        for (int i = 0; i < RF; i++) step(0, 8'h00, 0, 0, 0);
        check("play_rdy", 32'(gif.rdy), 32'd1);

        // Round 1: 5 passes, then 2 more, then crash with a simultaneous pass
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0, 1);
        check("score_5", 32'(gif.score), 32'h005);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 1, 1);
        check("crash_score_held", 32'(gif.score), 32'h007);
        for (int i = 0; i < CF; i++) step(0, 8'h00, 0, 0, 0);
        check("over_after_crash", 32'(gif.state_code), 32'(S_OVER));

        // Round 2 with w held from start through OVER
        step(0, 8'h1A, 0, 0, 0);
        for (int i = 0; i < RF; i++) step(0, 8'h1A, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h1A, 0, 0, 1);
        step(0, 8'h1A, 1, 0, 0);
        for (int i = 0; i < CF + 5; i++) step(0, 8'h1A, 0, 0, 0);
        check("held_no_restart", 32'(gif.state_code), 32'(S_OVER));
`ifdef FLAP_HISCORE_EN
        check("hiscore_keeps_best", 32'(gif.hiscore), 32'h007);
`else
        check("hiscore_tied_zero", 32'(gif.hiscore), 32'h000);
`endif
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'hCC, 0, 0, 0);
        check("restart_after_release", 32'(gif.state_code), 32'(S_READY));

        // Round 3: saturation at 999
        for (int i = 0; i < RF; i++) step(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 998; i++) step(0, 8'h00, 0, 0, 1);
        check("score_998", 32'(gif.score), 32'h998);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 1);
        check("score_sat_999", 32'(gif.score), 32'h999);
        step(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < CF; i++) step(0, 8'h00, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] k;
            int         r;
            r = int'($urandom_range(0, 15));
            case (r)
                12:      k = 8'h2C;
                13:      k = 8'h1A;
                14:      k = 8'hCC;
                15:      k = 8'($urandom);
                default: k = 8'h00;
            endcase
            step(($urandom % 500) == 0, k,
                 ($urandom % 40) == 0, ($urandom % 40) == 0, ($urandom % 3) == 0);
        end

        // Reset mid-PLAY at score 4
        step(1, 8'h00, 0, 0, 0);
        step(0, 8'h2C, 0, 0, 0);
        for (int i = 0; i < RF; i++) step(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 1);
        check("score_4", 32'(gif.score), 32'h004);
        step(1, 8'h00, 0, 0, 0);
        check("midplay_reset_state", 32'(gif.state_code), 32'(S_IDLE));
        check("midplay_reset_rdy", 32'(gif.rdy), 32'd0);
        check("midplay_reset_score", 32'(gif.score), 32'h000);
        check("midplay_reset_hiscore", 32'(gif.hiscore), 32'h000);

        // Key held across Reset release counts as a fresh press
        step(1, 8'h2C, 0, 0, 0);
        step(0, 8'h2C, 0, 0, 0);
        check("held_through_reset_starts", 32'(gif.state_code), 32'(S_READY));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
